proc_run_ctrl: RTL
==================

# proc_run_ctrl

Synthesizable run controller for the single-cycle processor. It sequences the processor's reset, enables execution for a bounded cycle budget, and stops on a processor halt request or budget expiry. It latches the final PC and cycle count. It sits between board-level clock/reset and the processor top, replacing bench-driven reset/finish sequencing in hardware builds.

## Interface
Parameters:
- RST_CYCLES, default 1: cycles `proc_reset` is held high after `start`; must be ≥1.
- RUN_CYCLES, default 18: maximum execution cycles; must be ≥1 and < 2^CNT_W.
- CNT_W, default 16: width of the cycle counter.

Ports:
- ref_clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset asserted).
- start  in  1  one-cycle request to begin a run; ignored outside IDLE/DONE.
- halt_req  in  1  processor halt indication, sampled only in RUN.
- pc  in  32  processor PC, captured on halt or timeout.
- proc_reset  out  1  active-high reset to the processor.
- proc_run  out  1  processor execute enable (clock-enable for PC and register-file writes).
- done  out  1  sticky run-complete flag.
- timeout  out  1  run ended by budget expiry, not halt; valid while done=1.
- cycle_count  out  CNT_W  number of completed RUN cycles.
- final_pc  out  32  PC at run end.

## Operation
- FSM states: IDLE, RST, RUN, DONE. All outputs are registered.
- Reset (reset=0 at an edge): the state becomes IDLE regardless of current state. Output values: proc_reset=1, proc_run=0, done=0, timeout=0, cycle_count=0, final_pc=0.
- IDLE: proc_reset=1, proc_run=0. When start=1, go to RST, load the reset counter with RST_CYCLES-1, and clear cycle_count.
- RST: proc_reset=1, proc_run=0. Decrement the reset counter. When it is 0, go to RUN.
- RUN: proc_reset=0, proc_run=1. cycle_count increments at each edge spent in RUN.
  - If halt_req=1, go to DONE. Set timeout=0 and final_pc←pc.
  - Otherwise, if cycle_count==RUN_CYCLES-1, go to DONE. Set timeout=1 and final_pc←pc.
  - If halt and budget expiry occur on the same edge, halt wins: timeout=0.
- DONE: proc_reset=0, proc_run=0 (processor state frozen for inspection). done=1. cycle_count, final_pc and timeout hold. When start=1, go to RST, clearing done, timeout and cycle_count; final_pc holds until the next run end.
- start in RST or RUN is ignored. halt_req outside RUN is ignored.
- cycle_count never exceeds RUN_CYCLES; no wrap is possible given the parameter constraint.

## Timing
- start=1 sampled at edge k: state=RST after k. The RST→RUN transition occurs at edge k+RST_CYCLES; proc_run=1 from then.
- proc_run is high for exactly n+1 cycles on halt, where n is the cycle_count value at the sampling edge. On timeout it is high for exactly RUN_CYCLES cycles.
- done rises on the edge that leaves RUN, the same edge proc_run falls. final_pc is valid in that same cycle.
- Minimum turnaround DONE→RST→RUN: RST_CYCLES+1 edges from start.
- reset=0 mid-RUN: proc_run=0 and proc_reset=1 after that edge. No partial results are retained.

## Structure
- Shared package `proc_pkg` holds `typedef enum logic [1:0] {IDLE, RST, RUN, DONE} run_state_t`, plus the PC width constant (32) shared with the processor top.
- Single module, no sub-module. The reset counter and cycle counter are inline registers. Parameter legality is checked by elaboration-time assertions.

## Test plan
- Power-up: reset=0 for 2 cycles → proc_reset=1, proc_run=0, done=0, cycle_count=0, final_pc=0.
- Timeout run with defaults: start pulse, no halt → proc_reset high 1 cycle after IDLE, then proc_run high 18 cycles. Then done=1, timeout=1, cycle_count=18, final_pc = pc of the last RUN edge.
- Halt run: halt_req=1 when cycle_count=5, pc=0x0000_0014 → done=1, timeout=0, cycle_count=6, final_pc=0x14, proc_run high 6 cycles.
- Simultaneous halt and expiry: halt_req=1 at cycle_count=17 → timeout=0, cycle_count=18.
- Restart and ignore: start pulses during RUN are ignored. A start in DONE clears done, timeout and cycle_count, and reruns. RST_CYCLES=3 gives a proc_reset high span of 3 cycles between the start edge and proc_run rising.
- Reset mid-run: reset=0 at cycle_count=7 → next cycle IDLE, proc_reset=1, proc_run=0, cycle_count=0, done=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the processor run controller and processor top.
package proc_pkg;

    localparam int PC_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

endpackage

// File: rtl/proc_run_ctrl_if.sv
// Control/status bundle between the board-side sequencer and the run controller.
interface proc_run_ctrl_if #(
    parameter int CNT_W = 16
);
    import proc_pkg::*;

    logic              start;
    logic              halt_req;
    logic [PC_W-1:0]   pc;
    logic              proc_reset;
    logic              proc_run;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [PC_W-1:0]   final_pc;

    modport master (
        output start, halt_req, pc,
        input  proc_reset, proc_run, done, timeout, cycle_count, final_pc
    );

    modport slave (
        input  start, halt_req, pc,
        output proc_reset, proc_run, done, timeout, cycle_count, final_pc
    );

endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller: sequences processor reset, runs for a bounded cycle budget,
// and latches the final PC and cycle count on halt or budget expiry.
//
// state | meaning
// IDLE  | processor held in reset, waiting for start
// RST   | processor reset held for RST_CYCLES cycles
// RUN   | processor executing, cycle budget counting
// DONE  | processor frozen, results held until next start
module proc_run_ctrl
    import proc_pkg::*;
#(
    parameter int RST_CYCLES = 1,
    parameter int RUN_CYCLES = 18,
    parameter int CNT_W      = 16
) (
    input  logic            ref_clk,
    input  logic            reset,
    proc_run_ctrl_if.slave  bus
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("proc_run_ctrl: RST_CYCLES must be >= 1");
    end
    if (RUN_CYCLES < 1 || 64'(RUN_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_run
        $error("proc_run_ctrl: RUN_CYCLES must be >= 1 and < 2**CNT_W");
    end

    run_state_t        state_q, state_d;
    logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   final_pc_q, final_pc_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              proc_reset_q, proc_reset_d;
    logic              proc_run_q, proc_run_d;

    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            cnt_q        <= '0;
            final_pc_q   <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            proc_reset_q <= 1'b1;
            proc_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cnt_q        <= cnt_d;
            final_pc_q   <= final_pc_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            proc_reset_q <= proc_reset_d;
            proc_run_q   <= proc_run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        cnt_d      = cnt_q;
        final_pc_d = final_pc_q;
        done_d     = done_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RST;
                    rst_cnt_d = RST_W'(RST_CYCLES - 1);
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            RST: begin
                if (rst_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q - RST_W'(1);
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Halt takes priority over budget expiry on the same edge.
                if (bus.halt_req) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    timeout_d  = 1'b0;
                    final_pc_d = bus.pc;
                end else if (cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    timeout_d  = 1'b1;
                    final_pc_d = bus.pc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        proc_reset_d = (state_d == IDLE) || (state_d == RST);
        proc_run_d   = (state_d == RUN);
    end

    assign bus.proc_reset  = proc_reset_q;
    assign bus.proc_run    = proc_run_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = cnt_q;
    assign bus.final_pc    = final_pc_q;

endmodule
